// File: rtl/multicycle_sequencer_if.sv
// Sequencer bus: decoder inputs, datapath flags and the CW/K control outputs.
// Master drives stimulus and decoder words; slave is the sequencer.
interface multicycle_sequencer_if #(
  parameter int CW_W   = 34,
  parameter int K_W    = 64,
  parameter int NUM_EX = 4,
  parameter int STEP_W = 2
) ();
  logic                     stall;
  logic                     mem_ready;
  logic [3:0]               status;
  logic [NUM_EX*CW_W-1:0]   dec_cw;
  logic [STEP_W:0]          dec_len;
  logic [NUM_EX-1:0]        dec_mem;
  logic [K_W-1:0]           dec_k;
  logic                     dec_cond_en;
  logic [3:0]               dec_cond_msk;
  logic                     dec_cond_inv;
  logic [CW_W-1:0]          CW;
  logic [K_W-1:0]           K;
  logic [1:0]               state;
  logic [STEP_W-1:0]        step;
  logic                     ir_load;
  logic                     instr_done;
  logic                     illegal;

  modport master (
    output stall, mem_ready, status,
    output dec_cw, dec_len, dec_mem, dec_k,
    output dec_cond_en, dec_cond_msk, dec_cond_inv,
    input  CW, K, state, step,
    input  ir_load, instr_done, illegal
  );

  modport slave (
    input  stall, mem_ready, status,
    input  dec_cw, dec_len, dec_mem, dec_k,
    input  dec_cond_en, dec_cond_msk, dec_cond_inv,
    output CW, K, state, step,
    output ir_load, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC[0..n-1] -> FETCH.
// Drives per-step decoder control words onto the registered CW/K bus.
module multicycle_sequencer #(
  parameter int CW_W   = 34,
  parameter int K_W    = 64,
  parameter int NUM_EX = 4,
  parameter int STEP_W = 2,
  parameter logic [CW_W-1:0] IF_CW =
    34'b01_1_11_01_0_0_1_0_00000_0_0_0_000000000000000,
  parameter logic [CW_W-1:0] NOP_CW = '0
) (
  input logic               clock,
  input logic               reset,
  multicycle_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10
  } state_t;

  localparam logic [STEP_W:0]   MAX_LEN   = (STEP_W+1)'(NUM_EX);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_EX-1);

  state_t            st_q, st_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;

  logic [CW_W-1:0]   cw_arr [NUM_EX];
  logic              cond;
  logic              len_bad;
  logic              last;
  logic              wait_mem;
  logic [STEP_W-1:0] step_inc;

  for (genvar i = 0; i < NUM_EX; i++) begin : g_cw
    assign cw_arr[i] = bus.dec_cw[i*CW_W +: CW_W];
  end

  assign cond     = (|(bus.status & bus.dec_cond_msk))
                    ^ bus.dec_cond_inv;
  assign len_bad  = (bus.dec_len == '0)
                    || (bus.dec_len > MAX_LEN);
  // LAST_STEP guard keeps step in range even if dec_len misbehaves
  assign last     = ({1'b0, step_q} == bus.dec_len - 1'b1)
                    || (step_q == LAST_STEP);
  assign wait_mem = bus.dec_mem[step_q] & ~bus.mem_ready;
  assign step_inc = step_q + 1'b1;

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    cw_d   = cw_q;
    k_d    = k_q;
    done_d = 1'b0;
    ill_d  = ill_q;
    if (!bus.stall) begin
      unique case (st_q)
        FETCH: begin
          if (bus.mem_ready) begin
            st_d = DECODE;
            cw_d = NOP_CW;
          end
        end
        DECODE: begin
          if (len_bad) begin
            ill_d  = 1'b1;
            st_d   = FETCH;
            cw_d   = IF_CW;
            done_d = 1'b1;
          end else if (bus.dec_cond_en && !cond) begin
            st_d   = FETCH;
            cw_d   = IF_CW;
            done_d = 1'b1;
          end else begin
            st_d   = EXEC;
            step_d = '0;
            cw_d   = cw_arr[0];
            k_d    = bus.dec_k;
          end
        end
        EXEC: begin
          if (wait_mem) begin
            st_d = EXEC;
          end else if (last) begin
            st_d   = FETCH;
            cw_d   = IF_CW;
            step_d = '0;
            done_d = 1'b1;
          end else begin
            step_d = step_inc;
            cw_d   = cw_arr[step_inc];
          end
        end
        default: begin
          st_d   = FETCH;
          step_d = '0;
          cw_d   = IF_CW;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= FETCH;
      step_q <= '0;
      cw_q   <= IF_CW;
      k_q    <= '0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      cw_q   <= cw_d;
      k_q    <= k_d;
      done_q <= done_d;
      ill_q  <= ill_d;
    end
  end

  assign bus.CW         = cw_q;
  assign bus.K          = k_q;
  assign bus.state      = st_q;
  assign bus.step       = step_q;
  assign bus.instr_done = done_q;
  assign bus.illegal    = ill_q;
  assign bus.ir_load    = (st_q == FETCH)
                          & bus.mem_ready & ~bus.stall;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer.
// Linear step sequence with hand-computed expectations.
module tb_multicycle_sequencer;
  localparam int CW_W   = 34;
  localparam int K_W    = 64;
  localparam int NUM_EX = 4;
  localparam int STEP_W = 2;

  localparam logic [CW_W-1:0] IF_CW =
    34'b01_1_11_01_0_0_1_0_00000_0_0_0_000000000000000;
  localparam logic [CW_W-1:0] WA = 34'h0_1111_1111;
  localparam logic [CW_W-1:0] WB = 34'h2_2222_2222;
  localparam logic [CW_W-1:0] WC = 34'h3_3333_3333;
  localparam logic [CW_W-1:0] WD = 34'h0_4444_4444;

  localparam logic [1:0] S_F = 2'b00;
  localparam logic [1:0] S_D = 2'b01;
  localparam logic [1:0] S_E = 2'b10;

  logic clock;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;

  multicycle_sequencer_if #(
    .CW_W(CW_W), .K_W(K_W),
    .NUM_EX(NUM_EX), .STEP_W(STEP_W)
  ) sif ();

  multicycle_sequencer #(
    .CW_W(CW_W), .K_W(K_W),
    .NUM_EX(NUM_EX), .STEP_W(STEP_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h, expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_sc(input string tag,
                        input logic [1:0] st,
                        input logic [STEP_W-1:0] stp,
                        input logic [CW_W-1:0] cw);
    chk({tag, ".state"}, 64'(sif.state), 64'(st));
    chk({tag, ".step"},  64'(sif.step),  64'(stp));
    chk({tag, ".cw"},    64'(sif.CW),    64'(cw));
  endtask

  initial begin
    reset            = 1'b1;
    sif.stall        = 1'b0;
    sif.mem_ready    = 1'b1;
    sif.status       = 4'b0000;
    sif.dec_cw       = {WD, WC, WB, WA};
    sif.dec_len      = 3'd2;
    sif.dec_mem      = 4'b0000;
    sif.dec_k        = 64'd5;
    sif.dec_cond_en  = 1'b0;
    sif.dec_cond_msk = 4'b0000;
    sif.dec_cond_inv = 1'b0;
    tick();
    tick();
    chk_sc("rst", S_F, 2'd0, IF_CW);
    chk("rst.k",    sif.K,          64'd0);
    chk("rst.done", 64'(sif.instr_done), 64'd0);
    chk("rst.ill",  64'(sif.illegal),    64'd0);

    // 1: two-step instruction, no waits
    reset = 1'b0;
    chk("t1.irload", 64'(sif.ir_load), 64'd1);
    tick();
    chk_sc("t1.dec", S_D, 2'd0, '0);
    chk("t1.dec.k", sif.K, 64'd0);
    tick();
    chk_sc("t1.e0", S_E, 2'd0, WA);
    chk("t1.e0.k", sif.K, 64'd5);
    tick();
    chk_sc("t1.e1", S_E, 2'd1, WB);
    tick();
    chk_sc("t1.f", S_F, 2'd0, IF_CW);
    chk("t1.done", 64'(sif.instr_done), 64'd1);

    // 2: single step waiting three cycles on memory
    sif.dec_len = 3'd1;
    sif.dec_mem = 4'b0001;
    tick();
    chk_sc("t2.dec", S_D, 2'd0, '0);
    chk("t2.dec.done", 64'(sif.instr_done), 64'd0);
    sif.mem_ready = 1'b0;
    tick();
    chk_sc("t2.e0", S_E, 2'd0, WA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_sc("t2.wait", S_E, 2'd0, WA);
      chk("t2.wait.done", 64'(sif.instr_done), 64'd0);
    end
    sif.mem_ready = 1'b1;
    tick();
    chk_sc("t2.f", S_F, 2'd0, IF_CW);
    chk("t2.done", 64'(sif.instr_done), 64'd1);

    // 3: condition false after inversion -> squash
    sif.dec_len      = 3'd2;
    sif.dec_mem      = 4'b0000;
    sif.dec_k        = 64'd9;
    sif.status       = 4'b0100;
    sif.dec_cond_msk = 4'b0100;
    sif.dec_cond_inv = 1'b1;
    sif.dec_cond_en  = 1'b1;
    tick();
    chk_sc("t3.dec", S_D, 2'd0, '0);
    tick();
    chk_sc("t3.f", S_F, 2'd0, IF_CW);
    chk("t3.k",    sif.K, 64'd5);
    chk("t3.done", 64'(sif.instr_done), 64'd1);

    // 4: same flags, no inversion -> executes
    sif.dec_cond_inv = 1'b0;
    tick();
    chk_sc("t4.dec", S_D, 2'd0, '0);
    chk("t4.dec.done", 64'(sif.instr_done), 64'd0);
    tick();
    chk_sc("t4.e0", S_E, 2'd0, WA);
    chk("t4.k", sif.K, 64'd9);
    tick();
    chk_sc("t4.e1", S_E, 2'd1, WB);
    tick();
    chk_sc("t4.f", S_F, 2'd0, IF_CW);
    chk("t4.done", 64'(sif.instr_done), 64'd1);

    // 5: illegal lengths, sticky flag
    sif.dec_cond_en = 1'b0;
    sif.dec_len     = 3'd0;
    tick();
    chk_sc("t5a.dec", S_D, 2'd0, '0);
    chk("t5a.dec.ill", 64'(sif.illegal), 64'd0);
    tick();
    chk_sc("t5a.f", S_F, 2'd0, IF_CW);
    chk("t5a.ill",  64'(sif.illegal),    64'd1);
    chk("t5a.done", 64'(sif.instr_done), 64'd1);
    chk("t5a.k",    sif.K, 64'd9);
    sif.dec_len = 3'd5;
    tick();
    tick();
    chk_sc("t5b.f", S_F, 2'd0, IF_CW);
    chk("t5b.ill",  64'(sif.illegal),    64'd1);
    chk("t5b.done", 64'(sif.instr_done), 64'd1);
    sif.dec_len = 3'd1;
    tick();
    tick();
    chk_sc("t5c.e0", S_E, 2'd0, WA);
    chk("t5c.ill", 64'(sif.illegal), 64'd1);
    tick();
    chk_sc("t5c.f", S_F, 2'd0, IF_CW);
    chk("t5c.ill", 64'(sif.illegal), 64'd1);

    // 6: full-length instruction, stall, then reset under stall
    sif.dec_len = 3'd4;
    sif.dec_k   = 64'd7;
    tick();
    tick();
    chk_sc("t6.e0", S_E, 2'd0, WA);
    tick();
    chk_sc("t6.e1", S_E, 2'd1, WB);
    sif.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_sc("t6.stall", S_E, 2'd1, WB);
      chk("t6.stall.k",    sif.K, 64'd7);
      chk("t6.stall.done", 64'(sif.instr_done), 64'd0);
    end
    sif.stall = 1'b0;
    tick();
    chk_sc("t6.e2", S_E, 2'd2, WC);
    sif.stall = 1'b1;
    reset     = 1'b1;
    tick();
    chk_sc("t6.rst", S_F, 2'd0, IF_CW);
    chk("t6.rst.k",    sif.K, 64'd0);
    chk("t6.rst.done", 64'(sif.instr_done), 64'd0);
    chk("t6.rst.ill",  64'(sif.illegal),    64'd0);
    reset = 1'b0;
    chk("t6.irload.stall", 64'(sif.ir_load), 64'd0);
    sif.stall = 1'b0;
    #1;
    chk("t6.irload", 64'(sif.ir_load), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule
